acc_bn_act_pipe: RTL and testbench

//  Multi-channel partial-sum accumulator with per-channel batch-norm, requantising shift, ReLU and saturation.

---
 rtl/acc_bn_act_pipe.sv | 164 ++++++++++++++++
 tb/tb_acc_bn_act_pipe.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/acc_bn_act_pipe.sv
// acc_bn_act_pipe: channel-interleaved psum accumulator with per-channel batch-norm,
// requantising shift, ReLU and output saturation behind valid/ready handshakes.
module acc_bn_act_pipe #(
  parameter int IN_WIDTH       = 32,
  parameter int ACC_WIDTH      = 40,
  parameter int OUT_WIDTH      = 16,
  parameter int NUM_CH         = 8,
  parameter int BN_SCALE_WIDTH = 16,
  parameter int BN_SHIFT_WIDTH = 16,
  parameter int LEN_WIDTH      = 8
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic [2:0]                               cfg_mode_i,
  input  logic [LEN_WIDTH-1:0]                     cfg_len_i,
  input  logic [5:0]                               cfg_rshift_i,
  input  logic                                     start_i,
  input  logic                                     bn_param_in_en_i,
  input  logic [BN_SCALE_WIDTH+BN_SHIFT_WIDTH-1:0] bn_param_in_i,
  output logic                                     bn_param_out_en_o,
  output logic [BN_SCALE_WIDTH+BN_SHIFT_WIDTH-1:0] bn_param_out_o,
  input  logic                                     in_valid_i,
  output logic                                     in_ready_o,
  input  logic signed [IN_WIDTH-1:0]               in_psum_i,
  output logic                                     out_valid_o,
  input  logic                                     out_ready_i,
  output logic signed [OUT_WIDTH-1:0]              out_data_o,
  output logic [$clog2(NUM_CH)-1:0]                out_ch_o,
  output logic                                     out_last_o,
  output logic                                     busy_o,
  output logic                                     done_o
);
  localparam int CW = $clog2(NUM_CH);
  localparam int BW = BN_SCALE_WIDTH + BN_SHIFT_WIDTH;
  localparam int PW = ACC_WIDTH + BN_SCALE_WIDTH + 1;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2;
  localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] mode_q;
  logic [LEN_WIDTH-1:0] len_q, pass_q;
  logic [5:0] rshift_q;
  logic [CW-1:0] ch_q, wptr_q, wptr_d, wsel, ch1_q, ch2_q, ch3_q, out_ch_q;
  logic signed [BN_SCALE_WIDTH-1:0] scale_q [NUM_CH];
  logic signed [BN_SHIFT_WIDTH-1:0] shift_q [NUM_CH];
  logic signed [ACC_WIDTH-1:0] acc_q [NUM_CH];
  logic signed [ACC_WIDTH-1:0] psum_x, acc_sel, sum_d, sum1_q;
  logic signed [ACC_WIDTH:0] sum_w;
  logic signed [PW-1:0] pre_d, pre2_q, shr, act_d, act3_q;
  logic signed [OUT_WIDTH-1:0] sat_d, out_data_q;
  logic [BW-1:0] bpo_q;
  logic bpo_en_q, done_q, out_valid_q, v1_q, v2_q, v3_q;
  logic idle, start, stall, accept, emit, ch_wrap, last_beat, pipe_empty;

  assign idle       = state_q == IDLE;
  assign start      = idle & start_i;
  assign stall      = out_valid_q & ~out_ready_i;
  assign in_ready_o = (state_q == RUN) & ~stall;
  assign accept     = in_valid_i & in_ready_o;
  assign emit       = accept & ((pass_q == len_q) | ~mode_q[2]);
  assign ch_wrap    = ch_q == LAST_CH;
  assign last_beat  = accept & ch_wrap & (pass_q == len_q);
  assign pipe_empty = ~(v1_q | v2_q | v3_q | out_valid_q);
  assign wptr_d     = (wptr_q == LAST_CH) ? '0 : wptr_q + CW'(1);
  assign wsel       = start ? '0 : wptr_q;

  assign bn_param_out_en_o = bpo_en_q;
  assign bn_param_out_o    = bpo_q;
  assign out_valid_o       = out_valid_q;
  assign out_data_o        = out_data_q;
  assign out_ch_o          = out_ch_q;
  assign out_last_o        = out_ch_q == LAST_CH;
  assign busy_o            = ~idle;
  assign done_o            = done_q;

  always_comb begin
    state_d = start ? RUN :
              (state_q == RUN && last_beat) ? DRAIN :
              (state_q == DRAIN && pipe_empty) ? IDLE : state_q;
    psum_x  = ACC_WIDTH'(in_psum_i);
    acc_sel = (pass_q == '0 || !mode_q[2]) ? '0 : acc_q[ch_q];
    sum_w   = (ACC_WIDTH+1)'(acc_sel) + (ACC_WIDTH+1)'(psum_x);
    sum_d   = (sum_w[ACC_WIDTH] != sum_w[ACC_WIDTH-1]) ?
              {sum_w[ACC_WIDTH], {(ACC_WIDTH-1){~sum_w[ACC_WIDTH]}}} : sum_w[ACC_WIDTH-1:0];
    pre_d   = mode_q[0] ? PW'(sum1_q) * PW'(scale_q[ch1_q]) + PW'(shift_q[ch1_q]) : PW'(sum1_q);
    shr     = pre2_q >>> rshift_q;
    act_d   = (mode_q[1] && shr[PW-1]) ? '0 : shr;
    // clamp to the output range when the upper bits are not a pure sign extension
    sat_d   = (act3_q == PW'($signed(act3_q[OUT_WIDTH-1:0]))) ? act3_q[OUT_WIDTH-1:0] :
              {act3_q[PW-1], {(OUT_WIDTH-1){~act3_q[PW-1]}}};
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q  <= IDLE;
      mode_q   <= '0;
      len_q    <= '0;
      rshift_q <= '0;
      ch_q     <= '0;
      pass_q   <= '0;
      wptr_q   <= '0;
      done_q   <= 1'b0;
      bpo_en_q <= 1'b0;
      bpo_q    <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= (state_q == DRAIN) & pipe_empty;
      bpo_en_q <= bn_param_in_en_i;
      bpo_q    <= bn_param_in_i;
      if (start) begin
        mode_q   <= cfg_mode_i;
        len_q    <= cfg_len_i;
        rshift_q <= cfg_rshift_i;
        ch_q     <= '0;
        pass_q   <= '0;
        wptr_q   <= bn_param_in_en_i ? CW'(1) : '0;
      end else if (idle && bn_param_in_en_i) wptr_q <= wptr_d;
      if (accept) begin
        ch_q <= ch_wrap ? '0 : ch_q + CW'(1);
        if (ch_wrap) pass_q <= pass_q + LEN_WIDTH'(1);
      end
    end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      for (int i = 0; i < NUM_CH; i++) begin
        scale_q[i] <= '0;
        shift_q[i] <= '0;
        acc_q[i]   <= '0;
      end
    end else begin
      if (idle && bn_param_in_en_i) {scale_q[wsel], shift_q[wsel]} <= bn_param_in_i;
      if (accept) acc_q[ch_q] <= sum_d;
    end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      v1_q        <= 1'b0;
      sum1_q      <= '0;
      ch1_q       <= '0;
      v2_q        <= 1'b0;
      pre2_q      <= '0;
      ch2_q       <= '0;
      v3_q        <= 1'b0;
      act3_q      <= '0;
      ch3_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else if (!stall) begin
      v1_q        <= emit;
      sum1_q      <= sum_d;
      ch1_q       <= ch_q;
      v2_q        <= v1_q;
      pre2_q      <= pre_d;
      ch2_q       <= ch1_q;
      v3_q        <= v2_q;
      act3_q      <= act_d;
      ch3_q       <= ch2_q;
      out_valid_q <= v3_q;
      out_data_q  <= sat_d;
      out_ch_q    <= ch3_q;
    end
endmodule

// File: tb/tb_acc_bn_act_pipe.sv
// tb_acc_bn_act_pipe: directed tiles with hand-computed activations, scoreboarded in order.
module tb_acc_bn_act_pipe;
  logic clk_i = 0, rst_ni = 0;
  logic [2:0] cfg_mode_i = '0;
  logic [7:0] cfg_len_i = '0;
  logic [5:0] cfg_rshift_i = '0;
  logic start_i = 0, bn_param_in_en_i = 0, in_valid_i = 0, out_ready_i = 1;
  logic [31:0] bn_param_in_i = '0, bn_param_out_o;
  logic signed [31:0] in_psum_i = '0;
  logic signed [15:0] out_data_o;
  logic [2:0] out_ch_o;
  logic bn_param_out_en_o, in_ready_o, out_valid_o, out_last_o, busy_o, done_o;
  int n_cmp = 0, n_bad = 0, done_cnt = 0;
  int exp_q[$], exp_ch_q[$];

  acc_bn_act_pipe dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cfg_mode_i(cfg_mode_i), .cfg_len_i(cfg_len_i),
    .cfg_rshift_i(cfg_rshift_i), .start_i(start_i), .bn_param_in_en_i(bn_param_in_en_i),
    .bn_param_in_i(bn_param_in_i), .bn_param_out_en_o(bn_param_out_en_o),
    .bn_param_out_o(bn_param_out_o), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_psum_i(in_psum_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_ch_o(out_ch_o), .out_last_o(out_last_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input longint obs, input longint expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  always @(negedge clk_i) begin
    if (done_o) done_cnt++;
    if (rst_ni && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) check("extra output", 1, 0);
      else begin
        check("out_last", out_last_o, exp_ch_q[0] == 7);
        check("out_ch", out_ch_o, exp_ch_q.pop_front());
        check("out_data", out_data_o, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_out(input int d, input int c);
    exp_q.push_back(d);
    exp_ch_q.push_back(c);
  endtask

  task automatic load_bn(input int sc, input int sh);
    for (int i = 0; i < 8; i++) begin
      bn_param_in_en_i = 1;
      bn_param_in_i = {16'(sc), 16'(sh)};
      tick();
    end
    bn_param_in_en_i = 0;
  endtask

  task automatic start_tile(input logic [2:0] m, input int len, input int rs, input bit wr = 0, input int sc = 0);
    cfg_mode_i = m;
    cfg_len_i = 8'(len);
    cfg_rshift_i = 6'(rs);
    start_i = 1;
    if (wr) begin
      bn_param_in_en_i = 1;
      bn_param_in_i = {16'(sc), 16'(0)};
    end
    tick();
    start_i = 0;
    bn_param_in_en_i = 0;
  endtask

  task automatic send(input int v);
    int n = 0;
    in_valid_i = 1;
    in_psum_i = v;
    @(negedge clk_i);
    while (!in_ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 200) check("in_ready timeout", 0, 1);
    tick();
    in_valid_i = 0;
  endtask

  task automatic finish_tile(input int d0);
    int t = 0;
    while (done_cnt == d0 && t < 300) begin
      tick();
      t++;
    end
    repeat (3) tick();
    check("done pulses", done_cnt - d0, 1);
    check("results left", exp_q.size(), 0);
    check("busy after done", busy_o, 0);
  endtask

  initial begin
    int d0;
    int vals[8];
    #2;
    check("rst out_valid", out_valid_o, 0);
    check("rst busy", busy_o, 0);
    check("rst in_ready", in_ready_o, 0);
    check("rst done", done_o, 0);
    check("rst out_data", out_data_o, 0);
    repeat (2) tick();
    rst_ni = 1;
    tick();

    load_bn(1, 0);
    check("bn pass en", bn_param_out_en_o, 1);
    check("bn pass data", bn_param_out_o, 32'h0001_0000);
    tick();
    check("bn pass en low", bn_param_out_en_o, 0);

    // three accumulated passes of ch+1
    d0 = done_cnt;
    for (int c = 0; c < 8; c++) expect_out(3 * (c + 1), c);
    start_tile(3'b100, 2, 0);
    check("busy in run", busy_o, 1);
    for (int p = 0; p < 3; p++) for (int c = 0; c < 8; c++) send(c + 1);
    finish_tile(d0);

    // BN with negative scale, ReLU on and off, plus emit latency
    load_bn(-2, 10);
    d0 = done_cnt;
    expect_out(4, 0); expect_out(0, 1);
    for (int c = 2; c < 8; c++) expect_out(10, c);
    start_tile(3'b011, 0, 0);
    send(3);
    @(negedge clk_i); check("latency +0", out_valid_o, 0);
    @(negedge clk_i);
    @(negedge clk_i); check("latency +2", out_valid_o, 0);
    @(negedge clk_i); check("latency +3", out_valid_o, 1);
    tick();
    send(8);
    for (int c = 2; c < 8; c++) send(0);
    finish_tile(d0);
    d0 = done_cnt;
    expect_out(-6, 0); expect_out(4, 1);
    for (int c = 2; c < 8; c++) expect_out(10, c);
    start_tile(3'b001, 0, 0);
    send(8); send(3);
    for (int c = 2; c < 8; c++) send(0);
    finish_tile(d0);

    // output saturation
    load_bn(32767, 0);
    d0 = done_cnt;
    expect_out(32767, 0); expect_out(-32768, 1); expect_out(-32767, 2);
    for (int c = 3; c < 8; c++) expect_out(0, c);
    start_tile(3'b001, 0, 0);
    send(32767); send(-32767); send(-1);
    for (int c = 3; c < 8; c++) send(0);
    finish_tile(d0);

    // floor shift; start with a simultaneous table write lands on entry 0
    load_bn(1, 0);
    d0 = done_cnt;
    expect_out(25, 0); expect_out(12, 1); expect_out(-13, 2);
    for (int c = 3; c < 8; c++) expect_out(1, c);
    start_tile(3'b001, 0, 3, 1, 2);
    send(100); send(100); send(-100);
    for (int c = 3; c < 8; c++) send(8);
    finish_tile(d0);

    // output backpressure for 10 cycles mid-run
    d0 = done_cnt;
    for (int c = 0; c < 8; c++) begin
      vals[c] = c * 10 - 5;
      expect_out(vals[c], c);
    end
    start_tile(3'b100, 0, 0);
    fork
      for (int c = 0; c < 8; c++) send(vals[c]);
      begin
        repeat (3) tick();
        out_ready_i = 0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk_i);
          if (out_valid_o) begin
            check("stall in_ready", in_ready_o, 0);
            check("stall hold", out_data_o, exp_q[0]);
          end
          tick();
        end
        out_ready_i = 1;
      end
    join
    finish_tile(d0);

    // reset in the middle of pass 1
    load_bn(3, 1);
    start_tile(3'b100, 2, 0);
    for (int i = 0; i < 10; i++) send(i % 8 + 1);
    #2 rst_ni = 0;
    #1;
    check("mid rst busy", busy_o, 0);
    check("mid rst out_valid", out_valid_o, 0);
    check("mid rst in_ready", in_ready_o, 0);
    check("mid rst out_data", out_data_o, 0);
    check("mid rst out_ch", out_ch_o, 0);
    check("mid rst bn_out", bn_param_out_o, 0);
    tick();
    rst_ni = 1;
    tick();
    d0 = done_cnt;
    for (int c = 0; c < 8; c++) expect_out(0, c);
    start_tile(3'b001, 0, 0);
    for (int c = 0; c < 8; c++) send(7);
    finish_tile(d0);
    load_bn(3, 1);
    d0 = done_cnt;
    for (int c = 0; c < 8; c++) expect_out((3 * c + 1) / 2, c);
    start_tile(3'b001, 0, 1);
    for (int c = 0; c < 8; c++) send(c);
    finish_tile(d0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end
endmodule
